// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and single-outstanding instruction fetch sequencer
module pc_fetch_unit #(
    parameter int                 BITSIZE  = 32,
    parameter logic [BITSIZE-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [BITSIZE-1:0] imem_addr,
    input  logic               imem_valid,
    input  logic [BITSIZE-1:0] imem_rdata,
    input  logic               branch_taken,
    input  logic [BITSIZE-1:0] branch_target,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [BITSIZE-1:0] if_instr,
    output logic [BITSIZE-1:0] if_pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [BITSIZE-1:0] PC_STEP = BITSIZE'(4);

    state_t             state_q, state_d;
    logic [BITSIZE-1:0] pc_q, pc_d;
    logic               kill_q, kill_d;
    logic [BITSIZE-1:0] if_instr_q, if_instr_d;
    logic [BITSIZE-1:0] if_pc_q, if_pc_d;
    logic               if_valid_q, if_valid_d;
    logic [BITSIZE-1:0] redirect_pc;

    assign redirect_pc = {branch_target[BITSIZE-1:2], 2'b00};

    // The request strobe is held low while reset is asserted even though state is REQ.
    assign imem_req  = (state_q == S_REQ) && !rst;
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;

        unique case (state_q)
            S_REQ: begin
                state_d = S_WAIT;
                if (branch_taken) begin
                    pc_d   = redirect_pc;
                    kill_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_valid) begin
                    if (kill_q || branch_taken) begin
                        // Response belongs to a squashed path: drop it and refetch.
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                        if (branch_taken) begin
                            pc_d = redirect_pc;
                        end
                    end else begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + PC_STEP;
                        state_d    = S_HOLD;
                    end
                end else if (branch_taken) begin
                    pc_d   = redirect_pc;
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (if_ready || branch_taken) begin
                    if_valid_d = 1'b0;
                    state_d    = S_REQ;
                    if (branch_taken) begin
                        pc_d = redirect_pc;
                    end
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer. It sits directly downstream of the branch-target adder and consumes that adder's target (PC + (imm<<2)).
- Selects the next PC (sequential PC+4 or redirect target) and issues single-outstanding requests to instruction memory.
- Presents each fetched instruction with its PC to decode over a valid/ready handshake.

Parameters:
- BITSIZE, 32, width of PC, addresses and instruction word
- RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request strobe; accepted in the cycle it is high
- imem_addr  out  BITSIZE  fetch byte address (bits[1:0] always 0)
- imem_valid  in  1  response strobe; one cycle, ≥1 cycle after imem_req
- imem_rdata  in  BITSIZE  instruction word, sampled when imem_valid=1
- branch_taken  in  1  redirect request, single-cycle pulse
- branch_target  in  BITSIZE  redirect byte address, from branch-target adder
- if_valid  out  1  instruction/PC available to decode
- if_ready  in  1  decode accepts; transfer occurs when if_valid & if_ready
- if_instr  out  BITSIZE  fetched instruction
- if_pc  out  BITSIZE  address of if_instr

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, state=REQ, kill=0.
  - if_valid=0, if_instr=0, if_pc=0, imem_req=0 during reset.
- Registers:
  - pc, state, kill flag.
  - Output buffer {if_instr, if_pc, if_valid}, all registered.
- imem_addr=pc and imem_req=(state==REQ), both combinational from registers.
- States and transitions:
  - REQ: request issued. Next WAIT. If branch_taken: pc<=target, kill<=1.
  - WAIT:
    - No imem_valid: stay in WAIT. If branch_taken: pc<=target, kill<=1.
    - imem_valid & kill (or imem_valid & branch_taken in the same cycle): discard response, kill<=0, go REQ. pc<=target if branch_taken this cycle, otherwise unchanged.
    - imem_valid, no kill, no branch_taken: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, go HOLD.
  - HOLD (if_valid=1):
    - if_valid & if_ready: if_valid<=0, go REQ. If branch_taken is also high this cycle, the transfer completes and pc<=target.
    - branch_taken without if_ready: buffered instruction dropped, if_valid<=0, pc<=target, go REQ.
    - Otherwise hold; buffer contents stable.
- Arithmetic:
  - pc+4 is modulo 2^BITSIZE; 32'hFFFF_FFFC+4 = 0.
  - Redirect loads {branch_target[BITSIZE-1:2], 2'b00}.
- Redirect has priority over sequential update in every state.
- The latest branch_taken overwrites pc if several arrive while in WAIT; kill stays 1.
- imem_valid outside WAIT is ignored.
- Latency:
  - Response to if_valid is 1 cycle.
  - Redirect in HOLD to imem_req at target is 1 cycle.
  - Steady-state throughput is one instruction per 3 cycles with a 1-cycle imem and if_ready=1.
- Reset mid-operation:
  - Pending response is forgotten: state=REQ, kill=0.
  - A late imem_valid after reset release is ignored because state≠WAIT.

Test Plan:
- Reset release, RESET_PC=0, imem latency 1, if_ready=1, rdata=addr^32'hA5A5_0000 -> imem_addr sequence 0,4,8,12; if_pc 0,4,8 with matching if_instr; if_valid pulses once per 3 cycles.
- if_ready=0 for 5 cycles after first response -> if_valid stays 1, if_pc=0 and if_instr stable; no imem_req; after ready, next imem_addr=4.
- branch_taken in WAIT with target 0x100, response 2 cycles later -> response discarded (if_valid stays 0); next imem_req at 0x100; if_pc=0x100.
- branch_taken with target 0x203 in same cycle as imem_valid -> response dropped; next imem_addr=0x200.
- Branch during HOLD without ready -> if_valid falls next cycle; imem_addr=target. Branch with ready in the same cycle -> transfer counted, next fetch at target.
- Fetch at 0xFFFF_FFFC -> next imem_addr=0. Assert rst mid-WAIT -> outputs clear immediately (async); after release the first imem_addr is RESET_PC and a stray imem_valid is ignored.
